// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on a simple dual-port block RAM, with a skid stage for one word per cycle.
// Define BRAM_FIFO_LEVEL_EN to add the registered level output and its counter.
module raw_sdp_block_ram #(
  parameter int abits       = 8,
  parameter int dbytes      = 4,
  parameter int blen        = 8,
  parameter bit write_first = 1'b0
) (
  input  logic                    clk,
  input  logic [dbytes-1:0]       a_we,
  input  logic [abits-1:0]        a_addr,
  input  logic [dbytes*blen-1:0]  a_data,
  input  logic                    b_en,
  input  logic [abits-1:0]        b_addr,
  output logic [dbytes*blen-1:0]  b_data
);

  logic [dbytes*blen-1:0] mem [2**abits];
  logic [dbytes*blen-1:0] b_fwd;

  always_ff @(posedge clk) begin
    for (int i = 0; i < dbytes; i++) begin
      if (a_we[i]) mem[a_addr][i*blen +: blen] <= a_data[i*blen +: blen];
    end
  end

  // Read-first returns the old contents on an address collision; write-first forwards the new bytes.
  always_comb begin
    b_fwd = mem[b_addr];
    if (write_first && (a_addr == b_addr)) begin
      for (int i = 0; i < dbytes; i++) begin
        if (a_we[i]) b_fwd[i*blen +: blen] = a_data[i*blen +: blen];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (b_en) b_data <= b_fwd;
  end

endmodule

module bram_fifo #(
  parameter int abits = 8,
  parameter int dbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [dbits-1:0] w_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [dbits-1:0] r_data
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [abits:0]   level
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             pend;
  logic             pend_nx;
  logic [abits:0]   wr_ptr;
  logic [abits:0]   rd_ptr;
  logic             init_done;
  logic             full;
  logic             w_fire;
  logic             hs;
  logic             can_fetch;
  logic             mid_vld;
  logic             load;
  logic             fetch;
  logic [dbits-1:0] ram_q;

  assign r_valid   = (state == VALID);
  assign w_ready   = init_done && !full;
  assign w_fire    = w_valid && w_ready;
  assign hs        = r_valid && r_ready;
  // wr_ptr only advances after its edge, so an entry is never fetched at the edge that writes it.
  assign can_fetch = (rd_ptr != wr_ptr);
  assign mid_vld   = (state == FETCH) || ((state == VALID) && pend);
  assign load      = mid_vld && (!r_valid || r_ready);
  assign fetch     = can_fetch && (!mid_vld || load);

`ifdef BRAM_FIFO_LEVEL_EN
  assign full = level[abits];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (w_fire && !hs) begin
      level <= level + 1'b1;
    end else if (hs && !w_fire) begin
      level <= level - 1'b1;
    end
  end
`else
  logic [abits:0] ack_ptr;

  // Words held in the skid or output register still occupy capacity until handed off.
  assign full = (wr_ptr[abits] != ack_ptr[abits]) &&
                (wr_ptr[abits-1:0] == ack_ptr[abits-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_ptr <= '0;
    end else if (hs) begin
      ack_ptr <= ack_ptr + 1'b1;
    end
  end
`endif

  // pend marks a fetched word waiting in the RAM output register behind a valid r_data.
  always_comb begin
    state_nx = EMPTY;
    pend_nx  = 1'b0;
    case (state)
      EMPTY: begin
        if (fetch) state_nx = FETCH;
      end
      FETCH: begin
        state_nx = VALID;
        pend_nx  = fetch;
      end
      VALID: begin
        if (!r_ready) begin
          state_nx = VALID;
          pend_nx  = pend || fetch;
        end else if (pend) begin
          state_nx = VALID;
          pend_nx  = fetch;
        end else if (fetch) begin
          state_nx = FETCH;
        end else begin
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      pend      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      init_done <= 1'b0;
      r_data    <= '0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      init_done <= 1'b1;
      if (w_fire) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)  rd_ptr <= rd_ptr + 1'b1;
      if (load)   r_data <= ram_q;
    end
  end

  raw_sdp_block_ram #(
    .abits       (abits),
    .dbytes      (1),
    .blen        (dbits),
    .write_first (1'b0)
  ) u_ram (
    .clk    (clk),
    .a_we   (w_fire),
    .a_addr (wr_ptr[abits-1:0]),
    .a_data (w_data),
    .b_en   (fetch),
    .b_addr (rd_ptr[abits-1:0]),
    .b_data (ram_q)
  );

endmodule

// File: tb/tb_bram_fifo.sv
// Directed bench for bram_fifo with abits=2: reset, latency, full, wrap, mid-run reset, randomized scoreboard.
module tb_bram_fifo;

  localparam int AB = 2;
  localparam int DB = 8;

  logic          clk;
  logic          rst_n;
  logic          w_valid;
  logic          w_ready;
  logic [DB-1:0] w_data;
  logic          r_valid;
  logic          r_ready;
  logic [DB-1:0] r_data;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AB:0]   level;
`endif

  int total = 0;
  int bad   = 0;

  bram_fifo #(.abits(AB), .dbits(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_data  (w_data),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_data  (r_data)
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_level(input string tag, input int exp);
`ifdef BRAM_FIFO_LEVEL_EN
    chk(tag, 32'(level), 32'(exp));
`else
    if (exp < 0) $display("level check skipped for %s", tag);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] q [$];
    logic [DB-1:0] exp4 [4];
    logic [DB-1:0] held;
    logic [DB-1:0] expv;
    logic          hold;
    int            sent;
    int            rcvd;
    int            cycles;

    rst_n = 1'b1; w_valid = 1'b0; w_data = '0; r_ready = 1'b0;

    // Reset forces outputs low asynchronously and w_ready stays low through reset edges.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_r_data",  32'(r_data),  32'd0);
    chk_level("rst_level", 0);
    step(); step();
    chk("rst_hold_w_ready", 32'(w_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("w_ready_after_rst", 32'(w_ready), 32'd1);
    chk("r_valid_after_rst", 32'(r_valid), 32'd0);

    // Single word: valid two edges after the write edge.
    w_valid = 1'b1; w_data = 8'hA1;
    step();
    w_valid = 1'b0;
    chk("lat_n_r_valid", 32'(r_valid), 32'd0);
    step();
    chk("lat_n1_r_valid", 32'(r_valid), 32'd0);
    step();
    chk("lat_n2_r_valid", 32'(r_valid), 32'd1);
    chk("lat_n2_r_data",  32'(r_data),  32'hA1);
    chk_level("lat_level", 1);
    step();
    chk("stall_r_data", 32'(r_data), 32'hA1);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("drain_r_valid", 32'(r_valid), 32'd0);
    chk_level("drain_level", 0);

    // Fill to capacity, then offer a fifth word that must be dropped.
    w_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      w_data = 8'(i);
      step();
      if (i < 4) chk("fill_w_ready", 32'(w_ready), 32'd1);
    end
    chk("full_w_ready", 32'(w_ready), 32'd0);
    w_data = 8'h05;
    step();
    chk("full_drop_w_ready", 32'(w_ready), 32'd0);
    chk("full_r_valid", 32'(r_valid), 32'd1);
    chk("full_r_data",  32'(r_data),  32'h01);
    chk_level("full_level", 4);

    // Write and read together while full: write refused this cycle, accepted the next.
    w_data = 8'h09; r_ready = 1'b1;
    chk("full_rw_w_ready", 32'(w_ready), 32'd0);
    step();
    r_ready = 1'b0;
    chk("w_ready_rise", 32'(w_ready), 32'd1);
    chk_level("after_read_level", 3);
    step();
    w_valid = 1'b0;
    chk("refull_w_ready", 32'(w_ready), 32'd0);
    exp4[0] = 8'h02; exp4[1] = 8'h03; exp4[2] = 8'h04; exp4[3] = 8'h09;
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_r_valid", 32'(r_valid), 32'd1);
      chk("order_r_data",  32'(r_data),  32'(exp4[i]));
      step();
    end
    r_ready = 1'b0;
    chk("order_empty", 32'(r_valid), 32'd0);
    chk_level("order_level", 0);

    // Continuous streaming across pointer wraps: one word per cycle after fill.
    r_ready = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      w_valid = (k < 12);
      w_data  = 8'(8'h10 + k);
      if (k < 12) chk("stream_w_ready", 32'(w_ready), 32'd1);
      step();
      if (k < 2 || k == 14) begin
        chk("stream_idle", 32'(r_valid), 32'd0);
      end else begin
        chk("stream_r_valid", 32'(r_valid), 32'd1);
        chk("stream_r_data",  32'(r_data),  32'(8'h10 + k - 2));
      end
    end
    w_valid = 1'b0; r_ready = 1'b0;

    // Mid-operation reset discards stored words.
    w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_data = 8'(8'h31 + i);
      step();
    end
    w_valid = 1'b0;
    step();
    chk("prerst_r_valid", 32'(r_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_r_valid", 32'(r_valid), 32'd0);
    chk("async_w_ready", 32'(w_ready), 32'd0);
    chk("async_r_data",  32'(r_data),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rerst_w_ready", 32'(w_ready), 32'd1);
    chk("rerst_r_valid", 32'(r_valid), 32'd0);
    step();
    chk("no_stale_r_valid", 32'(r_valid), 32'd0);
    w_valid = 1'b1; w_data = 8'h77;
    step();
    w_valid = 1'b0;
    step(); step();
    chk("post_rst_r_valid", 32'(r_valid), 32'd1);
    chk("post_rst_r_data",  32'(r_data),  32'h77);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("post_rst_empty", 32'(r_valid), 32'd0);

    // Randomized handshakes against a queue model.
    sent = 0; rcvd = 0; cycles = 0; hold = 1'b0; held = '0;
    while (rcvd < 10000 && cycles < 60000) begin
      w_valid = (sent < 10000) && ($urandom_range(0, 1) == 1);
      w_data  = 8'($urandom_range(0, 255));
      r_ready = ($urandom_range(0, 1) == 1);
      if (hold) begin
        chk("rand_stall_valid", 32'(r_valid), 32'd1);
        chk("rand_stall_data",  32'(r_data),  32'(held));
      end
      if (r_valid && r_ready) begin
        if (q.size() == 0) begin
          chk("rand_extra_word", 32'(r_valid), 32'd0);
        end else begin
          expv = q.pop_front();
          chk("rand_data", 32'(r_data), 32'(expv));
          rcvd++;
        end
      end
      hold = r_valid && !r_ready;
      held = r_data;
      if (w_valid && w_ready) begin
        q.push_back(w_data);
        sent++;
      end
      step();
      cycles++;
      chk_level("rand_level", q.size());
    end
    w_valid = 1'b0; r_ready = 1'b0;
    chk("rand_received", 32'(rcvd), 32'd10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_fifo.md
BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 Parameter abits, default 8: RAM address bits; FIFO capacity SHALL be 2**abits words.
REQ-002 Parameter dbits, default 32: word width in bits.
REQ-003 clk  input  1  single clock for all logic, rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 w_valid  input  1  write word offered.
REQ-006 w_ready  output  1  FIFO can accept a word.
REQ-007 w_data  input  dbits  write word.
REQ-008 r_valid  output  1  r_data holds the oldest stored word.
REQ-009 r_ready  input  1  consumer takes r_data.
REQ-010 r_data  output  dbits  oldest word; registered.
REQ-011 level  output  abits+1  stored word count; present only when BRAM_FIFO_LEVEL_EN is defined.

Function
REQ-012 Storage SHALL be one raw_sdp_block_ram instance.
- Parameters: abits=abits, dbytes=1, blen=dbits, write_first=0.
- Port a is driven by the write side and port b by the read prefetch.
REQ-013 A write SHALL occur on each rising edge with w_valid && w_ready, storing w_data at the write pointer; the write pointer SHALL increment modulo 2**abits.
REQ-014 A read handshake SHALL occur on each rising edge with r_valid && r_ready.
REQ-015 The FIFO SHALL be first-word-fall-through: whenever stored words exist, r_valid is high and r_data holds the oldest word.
REQ-016 Empty-to-valid latency: a word written at edge N into an empty FIFO SHALL give r_valid=1 at edge N+2, not earlier.
REQ-017 The read port SHALL never address an entry written at the same edge, because read_first mode returns stale data for such a read.
REQ-018 Prefetch states:
- EMPTY: no output word.
- FETCH: RAM read issued, data due next edge.
- VALID: output register loaded.
REQ-019 Prefetch state transitions:
- EMPTY->FETCH when a committed unread entry exists.
- FETCH->VALID on the next edge.
- VALID->FETCH on a handshake with further committed entries.
- VALID->EMPTY on a handshake with none.
- VALID is held without a handshake.
REQ-020 In VALID with r_ready held high and entries available, throughput SHALL be one word per cycle. This requires the next RAM read to be issued in the same cycle as the handshake, with an output skid register permitted.
REQ-021 Full: w_ready SHALL be 0 while 2**abits words are stored. w_valid while full SHALL be ignored, with no write and no pointer change.
REQ-022 Simultaneous write and read when full: w_ready stays 0 in that cycle. w_ready SHALL rise at the edge following the read.
REQ-023 Simultaneous write and read when neither full nor empty: the stored count SHALL be unchanged.
REQ-024 Pointer wrap from 2**abits-1 to 0 SHALL not disturb ordering or the full/empty decisions.
REQ-025 r_data SHALL be stable while r_valid && !r_ready.
REQ-026 Words SHALL be delivered exactly once, in write order.

Reset
REQ-027 While rst_n=0, the following SHALL be forced:
- w_ready=0, r_valid=0, r_data=0.
- level=0 when present.
- Pointers zero, prefetch state EMPTY.
REQ-028 w_ready SHALL become 1 at the first rising edge after rst_n deasserts.
REQ-029 Assertion of rst_n mid-operation SHALL discard all stored words immediately.
- RAM contents need not be cleared.
- No word written before reset SHALL appear after it.

Configuration
REQ-030 The macro BRAM_FIFO_LEVEL_EN SHALL control the level port and its count logic:
- Defined: port level exists, registered, equal to written minus read words including the word held in r_data, range 0..2**abits.
- Not defined: the port and its counter are absent, and full/empty are derived from pointers only.

Verification
REQ-031 abits=2 after reset: write 0xA1 at edge 1 with r_ready=0 -> r_valid=1, r_data=0xA1 at edge 3; level=1.
REQ-032 abits=2: write 0x1,0x2,0x3,0x4 back-to-back -> w_ready=0 after the 4th, a 5th value 0x5 is dropped; level=4; reads return 0x1..0x4, then r_valid=0.
REQ-033 Full FIFO with w_valid=1 (0x9) and r_ready=1 in the same cycle -> 0x1 read, 0x9 not accepted that cycle, accepted the next; order 0x2,0x3,0x4,0x9.
REQ-034 abits=2: stream 12 words 0x10..0x1B with w_valid=r_ready=1 continuously -> output 0x10..0x1B in order across 3 pointer wraps, one per cycle after the 2-cycle fill.
REQ-035 Pulse rst_n low with 3 words stored and r_valid=1 -> r_valid=0, w_ready=0 asynchronously; after release, write 0x77 -> first output 0x77.
REQ-036 Random w_valid/r_ready (50%), 10000 words vs. scoreboard -> no loss, duplication or reordering; r_data stable under stall; level matches model when BRAM_FIFO_LEVEL_EN is defined.
